// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game sequencer.
// Colours match the LED/button wiring; states are the controller's FSM.
package simon_pkg;

    typedef logic [1:0] colour_t;

    localparam colour_t RED    = 2'd0;
    localparam colour_t GREEN  = 2'd1;
    localparam colour_t BLUE   = 2'd2;
    localparam colour_t YELLOW = 2'd3;

    localparam int MAX_SEGMENTS = 32;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CLEAR    = 4'd1,
        ST_LOAD     = 4'd2,
        ST_SETTLE   = 4'd3,
        ST_SHOW_ON  = 4'd4,
        ST_SHOW_OFF = 4'd5,
        ST_INPUT    = 4'd6,
        ST_GAP      = 4'd7,
        ST_WIN      = 4'd8,
        ST_LOSE     = 4'd9
    } state_t;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// done is high whenever the count rests at zero; a load overrides counting.
module seq_timer #(
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/simon_sequence_ctrl.sv
// Simon game controller: grows the colour history, plays it back oldest-first,
// then checks the player's presses against it and reports win or lose.
module simon_sequence_ctrl
    import simon_pkg::*;
#(
    parameter int ON_CYCLES      = 12_500_000,
    parameter int OFF_CYCLES     = 6_250_000,
    parameter int TIMEOUT_CYCLES = 250_000_000,
    parameter int MAX_LEN        = MAX_SEGMENTS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   rand_colour,
    input  logic                         btn_valid,
    input  logic [1:0]                   btn_colour,
    input  logic [MAX_SEGMENTS:0][1:0]   segment,
    output logic                         seg_clear,
    output logic                         load_colour,
    output logic [1:0]                   new_colour,
    output logic                         led_en,
    output logic [1:0]                   led_colour,
    output logic [5:0]                   round_len,
    output logic                         accepting,
    output logic                         game_over,
    output logic                         game_won
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Timer is loaded with N-1 so a phase lasts exactly N cycles including its entry cycle.
    localparam logic [TW-1:0] ON_LOAD      = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD     = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_n;
    logic [5:0]    idx, idx_n;
    logic [5:0]    len_n;
    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_done;

    seq_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        len_n     = round_len;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) state_n = ST_CLEAR;
            end
            ST_CLEAR: begin
                len_n   = '0;
                state_n = ST_LOAD;
            end
            ST_LOAD: begin
                len_n   = round_len + 6'd1;
                state_n = ST_SETTLE;
            end
            ST_SETTLE: begin
                idx_n     = round_len;
                tmr_load  = 1'b1;
                tmr_value = ON_LOAD;
                state_n   = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (tmr_done) begin
                    tmr_load  = 1'b1;
                    tmr_value = OFF_LOAD;
                    state_n   = ST_SHOW_OFF;
                end
            end
            ST_SHOW_OFF: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (idx > 6'd1) begin
                        idx_n     = idx - 6'd1;
                        tmr_value = ON_LOAD;
                        state_n   = ST_SHOW_ON;
                    end else begin
                        idx_n     = round_len;
                        tmr_value = TIMEOUT_LOAD;
                        state_n   = ST_INPUT;
                    end
                end
            end
            // A press on the final timeout cycle wins over the timeout.
            ST_INPUT: begin
                if (btn_valid) begin
                    if (btn_colour == segment[idx]) begin
                        if (idx > 6'd1) begin
                            idx_n     = idx - 6'd1;
                            tmr_load  = 1'b1;
                            tmr_value = TIMEOUT_LOAD;
                        end else if (round_len == 6'(MAX_LEN)) begin
                            state_n = ST_WIN;
                        end else begin
                            tmr_load  = 1'b1;
                            tmr_value = OFF_LOAD;
                            state_n   = ST_GAP;
                        end
                    end else begin
                        state_n = ST_LOSE;
                    end
                end else if (tmr_done) begin
                    state_n = ST_LOSE;
                end
            end
            ST_GAP: begin
                if (tmr_done) state_n = ST_LOAD;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so each one is a flop yet tracks the state exactly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            round_len   <= '0;
            seg_clear   <= 1'b0;
            load_colour <= 1'b0;
            new_colour  <= RED;
            led_en      <= 1'b0;
            led_colour  <= RED;
            accepting   <= 1'b0;
            game_over   <= 1'b0;
            game_won    <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            round_len   <= len_n;
            seg_clear   <= (state_n == ST_CLEAR);
            load_colour <= (state_n == ST_LOAD);
            new_colour  <= (state_n == ST_LOAD) ? rand_colour : RED;
            led_en      <= (state_n == ST_SHOW_ON);
            led_colour  <= (state_n == ST_SHOW_ON) ? segment[idx_n] : RED;
            accepting   <= (state_n == ST_INPUT);
            game_over   <= (state_n == ST_WIN) || (state_n == ST_LOSE);
            game_won    <= (state_n == ST_WIN);
        end
    end

endmodule

// File: tb/tb_simon_sequence_ctrl.sv
// Self-checking bench for simon_sequence_ctrl with short timings and a behavioural
// segments_array stand-in; expectations come from a queue of the colours the bench chose.
module tb_simon_sequence_ctrl;
    import simon_pkg::*;

    localparam int ON   = 3;
    localparam int OFF  = 2;
    localparam int TO   = 10;
    localparam int MAXL = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    colour_t             rand_colour;
    logic                btn_valid;
    colour_t             btn_colour;
    logic [32:0][1:0]    segment;
    logic                seg_clear;
    logic                load_colour;
    colour_t             new_colour;
    logic                led_en;
    colour_t             led_colour;
    logic [5:0]          round_len;
    logic                accepting;
    logic                game_over;
    logic                game_won;

    int      checks = 0;
    int      errors = 0;
    colour_t hist_q[$];
    logic [32:0][1:0] seg_mem;

    simon_sequence_ctrl #(
        .ON_CYCLES      (ON),
        .OFF_CYCLES     (OFF),
        .TIMEOUT_CYCLES (TO),
        .MAX_LEN        (MAXL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rand_colour (rand_colour),
        .btn_valid   (btn_valid),
        .btn_colour  (btn_colour),
        .segment     (segment),
        .seg_clear   (seg_clear),
        .load_colour (load_colour),
        .new_colour  (new_colour),
        .led_en      (led_en),
        .led_colour  (led_colour),
        .round_len   (round_len),
        .accepting   (accepting),
        .game_over   (game_over),
        .game_won    (game_won)
    );

    always #5 clk = ~clk;

    // Stand-in for segments_array: the newest colour lands at [1], older ones move up.
    always @(posedge clk) begin
        if (!reset || seg_clear) seg_mem <= '0;
        else if (load_colour) seg_mem[32:1] <= {seg_mem[31:1], new_colour};
    end
    assign segment = seg_mem;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_colour = RED; rand_colour = RED;
        repeat (3) tick();
        checks++;
        if ({seg_clear, load_colour, new_colour, led_en, led_colour, accepting, game_over, game_won} !== 10'd0
            || round_len !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b len=%0d, want all 0 len=0",
                     {seg_clear, load_colour, new_colour, led_en, led_colour, accepting, game_over, game_won}, round_len);
        end
        reset = 1'b1;
        btn_valid = 1'b1;
        tick();
        btn_valid = 1'b0;
        tick();
        checks++;
        if ({seg_clear, load_colour, led_en, accepting, game_over, game_won} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL idle_quiet: got %b, want 000000",
                     {seg_clear, load_colour, led_en, accepting, game_over, game_won});
        end
    endtask

    task automatic begin_game(input colour_t r);
        start = 1'b1;
        rand_colour = r;
        tick();
        start = 1'b0;
        checks++;
        if (seg_clear !== 1'b1 || load_colour !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_clear: got clr=%b load=%b over=%b, want 1 0 0", seg_clear, load_colour, game_over);
        end
        tick();
        checks++;
        if (load_colour !== 1'b1 || new_colour !== r || round_len !== 6'd0) begin
            errors++;
            $display("[TB] FAIL start_load: got load=%b colour=%0d len=%0d, want 1 %0d 0",
                     load_colour, new_colour, round_len, r);
        end
        hist_q.delete();
        hist_q.push_back(r);
    endtask

    task automatic check_playback(input bit noise);
        tick();
        checks++;
        if (led_en !== 1'b0 || round_len !== 6'(hist_q.size())) begin
            errors++;
            $display("[TB] FAIL settle: got en=%b len=%0d, want 0 %0d", led_en, round_len, hist_q.size());
        end
        for (int i = 0; i < hist_q.size(); i++) begin
            for (int c = 0; c < ON + OFF; c++) begin
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    btn_valid = 1'($urandom_range(0, 1));
                    btn_colour = colour_t'($urandom_range(0, 3));
                end
                rand_colour = colour_t'($urandom_range(0, 3));
                tick();
                checks++;
                if (c < ON) begin
                    if (led_en !== 1'b1 || led_colour !== hist_q[i] || accepting !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL show_on[%0d.%0d]: got en=%b colour=%0d acc=%b, want 1 %0d 0",
                                 i, c, led_en, led_colour, accepting, hist_q[i]);
                    end
                end else if (led_en !== 1'b0 || accepting !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL show_off[%0d.%0d]: got en=%b acc=%b, want 0 0", i, c, led_en, accepting);
                end
            end
        end
        start = 1'b0;
        btn_valid = 1'b0;
        tick();
        checks++;
        if (accepting !== 1'b1 || led_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL enter_input: got acc=%b en=%b, want 1 0", accepting, led_en);
        end
    endtask

    task automatic press(input colour_t c, input int wait_cycles);
        for (int w = 0; w < wait_cycles; w++) begin
            tick();
            checks++;
            if (accepting !== 1'b1 || game_over !== 1'b0) begin
                errors++;
                $display("[TB] FAIL waiting[%0d]: got acc=%b over=%b, want 1 0", w, accepting, game_over);
            end
        end
        btn_valid = 1'b1;
        btn_colour = c;
        tick();
        btn_valid = 1'b0;
    endtask

    // Plays every colour correctly; fixed_wait < 0 picks random think times within the timeout.
    task automatic play_input(input colour_t next_r, input int fixed_wait);
        int n = hist_q.size();
        for (int i = 0; i < n; i++) begin
            rand_colour = next_r;
            press(hist_q[i], (fixed_wait < 0) ? int'($urandom_range(0, TO - 1)) : fixed_wait);
            if (i < n - 1) begin
                checks++;
                if (accepting !== 1'b1 || game_over !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mid_press[%0d]: got acc=%b over=%b, want 1 0", i, accepting, game_over);
                end
            end
        end
        if (n == MAXL) begin
            checks++;
            if (game_won !== 1'b1 || game_over !== 1'b1 || accepting !== 1'b0 || round_len !== 6'(MAXL)) begin
                errors++;
                $display("[TB] FAIL win: got won=%b over=%b acc=%b len=%0d, want 1 1 0 %0d",
                         game_won, game_over, accepting, round_len, MAXL);
            end
        end else begin
            for (int c = 0; c < OFF; c++) begin
                checks++;
                if (led_en !== 1'b0 || accepting !== 1'b0 || load_colour !== 1'b0 || game_over !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gap[%0d]: got en=%b acc=%b load=%b over=%b, want 0 0 0 0",
                             c, led_en, accepting, load_colour, game_over);
                end
                tick();
            end
            checks++;
            if (load_colour !== 1'b1 || new_colour !== next_r) begin
                errors++;
                $display("[TB] FAIL next_load: got load=%b colour=%0d, want 1 %0d", load_colour, new_colour, next_r);
            end
            hist_q.push_back(next_r);
        end
    endtask

    task automatic test_timeout();
        begin_game(BLUE);
        check_playback(1'b1);
        for (int t = 1; t < TO; t++) begin
            tick();
            checks++;
            if (accepting !== 1'b1 || game_over !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pre_timeout[%0d]: got acc=%b over=%b, want 1 0", t, accepting, game_over);
            end
        end
        tick();
        checks++;
        if (game_over !== 1'b1 || game_won !== 1'b0 || accepting !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_lose: got over=%b won=%b acc=%b, want 1 0 0", game_over, game_won, accepting);
        end
    endtask

    task automatic test_history_mismatch();
        begin_game(GREEN);
        check_playback(1'b0);
        play_input(YELLOW, TO - 1);
        check_playback(1'b0);
        press(GREEN, int'($urandom_range(0, TO - 1)));
        checks++;
        if (accepting !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_of_two: got acc=%b, want 1", accepting);
        end
        press(RED, 0);
        checks++;
        if (game_over !== 1'b1 || game_won !== 1'b0 || accepting !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mismatch_lose: got over=%b won=%b acc=%b, want 1 0 0", game_over, game_won, accepting);
        end
        press(YELLOW, 0);
        tick();
        checks++;
        if (game_over !== 1'b1 || game_won !== 1'b0 || load_colour !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lose_held: got over=%b won=%b load=%b, want 1 0 0", game_over, game_won, load_colour);
        end
    endtask

    task automatic test_win();
        begin_game(colour_t'($urandom_range(0, 3)));
        check_playback(1'b1);
        play_input(colour_t'($urandom_range(0, 3)), -1);
        check_playback(1'b0);
        play_input(colour_t'($urandom_range(0, 3)), TO - 1);
        check_playback(1'b1);
        play_input(RED, -1);
        for (int k = 0; k < 3; k++) begin
            btn_valid = 1'b1;
            btn_colour = colour_t'($urandom_range(0, 3));
            tick();
            btn_valid = 1'b0;
            checks++;
            if (game_won !== 1'b1 || game_over !== 1'b1 || accepting !== 1'b0
                || load_colour !== 1'b0 || round_len !== 6'(MAXL)) begin
                errors++;
                $display("[TB] FAIL win_held[%0d]: got won=%b over=%b acc=%b load=%b len=%0d, want 1 1 0 0 %0d",
                         k, game_won, game_over, accepting, load_colour, round_len, MAXL);
            end
        end
    endtask

    task automatic test_back_to_back();
        begin_game(colour_t'($urandom_range(0, 3)));
        check_playback(1'b0);
        play_input(colour_t'($urandom_range(0, 3)), -1);
        check_playback(1'b1);
        press(colour_t'(hist_q[0] + 2'd1), int'($urandom_range(0, TO - 1)));
        checks++;
        if (game_over !== 1'b1 || game_won !== 1'b0 || accepting !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_lose: got over=%b won=%b acc=%b, want 1 0 0", game_over, game_won, accepting);
        end
    endtask

    task automatic test_reset_mid();
        begin_game(colour_t'($urandom_range(0, 3)));
        check_playback(1'b0);
        play_input(colour_t'($urandom_range(0, 3)), -1);
        tick();
        tick();
        checks++;
        if (led_en !== 1'b1 || led_colour !== hist_q[0]) begin
            errors++;
            $display("[TB] FAIL pre_reset_show: got en=%b colour=%0d, want 1 %0d", led_en, led_colour, hist_q[0]);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({seg_clear, load_colour, new_colour, led_en, led_colour, accepting, game_over, game_won} !== 10'd0
            || round_len !== 6'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %b len=%0d, want all 0 len=0",
                     {seg_clear, load_colour, new_colour, led_en, led_colour, accepting, game_over, game_won}, round_len);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (led_en !== 1'b0 || round_len !== 6'd0 || accepting !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got en=%b len=%0d acc=%b, want 0 0 0", led_en, round_len, accepting);
        end
        begin_game(colour_t'($urandom_range(0, 3)));
        check_playback(1'b0);
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_history_mismatch();
        test_win();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
